bp_inflight_scheduler: RTL
==========================

// Module: bp_inflight_scheduler
// PURPOSE
//  Sequences the gshare branch predictor between fetch and execute. Grants fetch
//  prediction slots and records each in-flight prediction in an in-order queue.
//  Pops the oldest entry when execute resolves it, drives the training interface
//  one cycle later, and raises a flush on misprediction.
//  Sits between fetch, the predictor and the execute stage of uDarkRISC.
// PARAMETERS
//  DEPTH   4   in-flight branch entries; power of 2, >=2
//  PC_W    16  PC width
//  HIST_W  8   global history width (matches predictor)
// PORTS
//  CLK                 in   1       clock, all state on posedge
//  RES                 in   1       asynchronous active-low reset
//  fe_req              in   1       fetch presents a conditional branch for prediction
//  fe_pc               in   PC_W    PC of that branch
//  fe_grant            out  1       prediction slot granted this cycle (comb)
//  fe_taken            out  1       predicted direction to fetch (comb, = bp_predict_taken when granted, else 0)
//  bp_predict_valid    out  1       = fe_grant
//  bp_predict_pc       out  PC_W    = fe_pc
//  bp_predict_taken    in   1       predictor result
//  bp_predict_history  in   HIST_W  predictor history at prediction time
//  ex_resolve_valid    in   1       execute resolves oldest in-flight branch
//  ex_resolve_taken    in   1       actual outcome
//  ex_resolve_ready    out  1       queue non-empty (comb)
//  bp_train_valid      out  1       registered training strobe
//  bp_train_taken      out  1       registered actual outcome
//  bp_train_mispredicted out 1      registered mispredict flag
//  bp_train_history    out  HIST_W  registered history of trained entry
//  bp_train_pc         out  PC_W    registered PC of trained entry
//  flush               out  1       registered 1-cycle pulse on mispredict
//  inflight_count      out  $clog2(DEPTH)+1  entries currently queued
// BEHAVIOUR
//  - Reset (RES=0, async): queue empty, rd/wr pointers 0, count 0; all registered outputs 0.
//  - Entry = {pc, history, predicted}. Circular buffer, pointers wrap modulo DEPTH.
//  - mis_now = ex_resolve_valid & ~empty & (ex_resolve_taken != head.predicted).
//  - fe_grant = fe_req & ~full & ~mis_now & ~flush. Full blocks grant even if a pop
//    occurs the same cycle (no bypass). Grant pushes {fe_pc, bp_predict_history, bp_predict_taken}.
//  - Pop when ex_resolve_valid & ~empty. Resolve while empty: ignored, no training, no flush.
//  - Simultaneous push and pop (no mispredict): both happen, count unchanged.
//  - Training: pop at edge N -> bp_train_* valid during cycle N+1 for exactly 1 cycle;
//    bp_train_mispredicted = mis at pop; data fields hold last value when valid=0.
//  - Mispredict: at the pop edge, queue cleared (count 0, rd=wr); younger entries
//    discarded, never trained. flush=1 during the same cycle as bp_train_valid.
//    No grant in the mispredict cycle nor the flush cycle (1-cycle fetch bubble).
//  - inflight_count registered; never exceeds DEPTH, never underflows.
//  - Reset mid-operation: queue and pending train/flush dropped immediately.
// CONFIGURATION
//  BP_STATS_EN defined: adds outputs stat_pred_cnt[15:0] (+1 per grant) and
//   stat_mispred_cnt[15:0] (+1 per mispredict pop); both saturate at 16'hFFFF, reset 0.
//  BP_STATS_EN undefined: these ports and counters do not exist; behaviour otherwise identical.
// TESTING
//  1 Reset: RES=0 mid-traffic -> count=0, flush=0, bp_train_valid=0, fe_grant follows fe_req.
//  2 Correct predict: grant pc=16'h0040 pred=1 hist=8'h5A; resolve taken=1 -> next cycle
//    train_valid=1, mispred=0, pc=16'h0040, hist=8'h5A; flush=0; count 1->0.
//  3 Full: 4 grants (DEPTH=4), 5th fe_req -> fe_grant=0; resolve+req same cycle -> still 0.
//  4 Mispredict with 3 queued: head pred=0, resolve taken=1 -> train mispred=1, flush=1
//    one cycle, count=0, no grant for 2 cycles, remaining 2 entries never trained.
//  5 Resolve on empty queue -> no train_valid, no flush, count stays 0.
//  6 Wrap: 10 push/pop pairs in steady state -> train PCs in issue order, count constant 1.

Source files
------------

// File: rtl/bp_inflight_scheduler.sv
// Purpose: grants gshare prediction slots to fetch, tracks in-flight branches in order, trains on resolve.
// Latency: fe_grant/fe_taken combinational; training strobe and flush one cycle after the resolving pop.
// Backpressure: no grant while full, in a mispredict cycle or in the flush cycle; optional BP_STATS_EN adds counters.
module bp_inflight_scheduler #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 16,
  parameter int HIST_W = 8
) (
  input  logic                       CLK,
  input  logic                       RES,
  input  logic                       fe_req,
  input  logic [PC_W-1:0]            fe_pc,
  output logic                       fe_grant,
  output logic                       fe_taken,
  output logic                       bp_predict_valid,
  output logic [PC_W-1:0]            bp_predict_pc,
  input  logic                       bp_predict_taken,
  input  logic [HIST_W-1:0]          bp_predict_history,
  input  logic                       ex_resolve_valid,
  input  logic                       ex_resolve_taken,
  output logic                       ex_resolve_ready,
  output logic                       bp_train_valid,
  output logic                       bp_train_taken,
  output logic                       bp_train_mispredicted,
  output logic [HIST_W-1:0]          bp_train_history,
  output logic [PC_W-1:0]            bp_train_pc,
  output logic                       flush,
  output logic [$clog2(DEPTH):0]     inflight_count
`ifdef BP_STATS_EN
  ,
  output logic [15:0]                stat_pred_cnt,
  output logic [15:0]                stat_mispred_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0]   q_pc   [DEPTH];
  logic [HIST_W-1:0] q_hist [DEPTH];
  logic              q_pred [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic empty;
  logic full;
  logic pop;
  logic mis_now;
  logic push;

  // Queue status, mispredict detection and fetch grant decision.
  always_comb begin
    empty    = (count == '0);
    full     = (count == DEPTH_C);
    pop      = ex_resolve_valid & ~empty;
    mis_now  = pop & (ex_resolve_taken != q_pred[rd_ptr]);
    // Full blocks the grant even when a pop frees a slot this cycle: no bypass path.
    push     = fe_req & ~full & ~mis_now & ~flush;
  end

  assign fe_grant         = push;
  assign fe_taken         = push & bp_predict_taken;
  assign bp_predict_valid = push;
  assign bp_predict_pc    = fe_pc;
  assign ex_resolve_ready = ~empty;
  assign inflight_count   = count;

  // Entry storage: written on grant, no reset needed since count gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_pc[wr_ptr]   <= fe_pc;
      q_hist[wr_ptr] <= bp_predict_history;
      q_pred[wr_ptr] <= bp_predict_taken;
    end
  end

  // Pointers and occupancy; a mispredict discards every younger entry at once.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mis_now) begin
      // push is suppressed in a mispredict cycle, so wr_ptr is already final.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered training interface and flush pulse, one cycle after the pop.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      bp_train_valid        <= 1'b0;
      bp_train_taken        <= 1'b0;
      bp_train_mispredicted <= 1'b0;
      bp_train_history      <= '0;
      bp_train_pc           <= '0;
      flush                 <= 1'b0;
    end else begin
      bp_train_valid <= pop;
      flush          <= mis_now;
      if (pop) begin
        bp_train_taken        <= ex_resolve_taken;
        bp_train_mispredicted <= mis_now;
        bp_train_history      <= q_hist[rd_ptr];
        bp_train_pc           <= q_pc[rd_ptr];
      end
    end
  end

`ifdef BP_STATS_EN
  // Saturating prediction and mispredict counters.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      stat_pred_cnt    <= '0;
      stat_mispred_cnt <= '0;
    end else begin
      if (push && stat_pred_cnt != 16'hFFFF)       stat_pred_cnt    <= stat_pred_cnt + 16'd1;
      if (mis_now && stat_mispred_cnt != 16'hFFFF) stat_mispred_cnt <= stat_mispred_cnt + 16'd1;
    end
  end
`endif

endmodule
